// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiters.
// Holds the arbiter state encoding, Wishbone cycle/burst type constants and a
// constant-evaluable clog2 used to size the round-robin pointer.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StAbort
  } arb_state_e;

  // Wishbone B3 cycle type identifiers
  localparam logic [2:0] CtiClassic = 3'b000;
  localparam logic [2:0] CtiIncr    = 3'b010;
  localparam logic [2:0] CtiEob     = 3'b111;

  // Wishbone B3 burst type identifiers
  localparam logic [1:0] BteLinear  = 2'b00;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i - request vector, one bit per requester
//   ptr_i - index of the highest-priority requester this round
//   gnt_o - one-hot grant for the first requester at or after ptr_i (wrapping);
//           all zero when nothing requests
module wb_rr_pick #(
  parameter int unsigned N    = 2,
  parameter int unsigned PtrW = 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o
);

  logic [N-1:0] hi_req;
  logic [N-1:0] sel_req;

  always_comb begin
    hi_req = '0;
    for (int i = 0; i < N; i++) begin
      hi_req[i] = req_i[i] && (i >= int'(ptr_i));
    end
    // Requesters at or above ptr win; otherwise wrap to the lowest index.
    sel_req = (|hi_req) ? hi_req : req_i;
    gnt_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel_req[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: merges NUM_MASTERS core-side master ports
// (flattened, slice k = master k) onto one shared master port. Ownership is
// held for the whole cyc so bursts stay atomic; a watchdog aborts strobes the
// slave never answers and returns err to the owner.
// Ports:
//   wb_clk_i, wb_rst_i            - clock, asynchronous active-high reset
//   wbm_*_i                       - core-side master requests (flattened)
//   wbm_dat_o                     - slave read data broadcast to every slice
//   wbm_ack_o/err_o/rty_o         - responses, only the owner sees them
//   wbs_*_o                       - muxed request towards the interconnect
//   wbs_dat_i, wbs_ack_i/err_i/rty_i - slave responses
//   grant_o                       - one-hot current owner
//   timeout_o                     - one-cycle pulse on each watchdog abort
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned dw          = 32,
  parameter int unsigned aw          = 32,
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned CW          = 11
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [aw*NUM_MASTERS-1:0] wbm_adr_i,
  input  logic [dw*NUM_MASTERS-1:0] wbm_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [3*NUM_MASTERS-1:0]  wbm_cti_i,
  input  logic [2*NUM_MASTERS-1:0]  wbm_bte_i,
  output logic [dw*NUM_MASTERS-1:0] wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  output logic [aw-1:0]             wbs_adr_o,
  output logic [dw-1:0]             wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [dw-1:0]             wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      timeout_o
);

  localparam int unsigned PtrW      = (NUM_MASTERS > 1) ? clog2(NUM_MASTERS) : 1;
  localparam bit          WdEn      = (TIMEOUT > 0);
  localparam logic [CW-1:0] TimeoutCw = CW'(TIMEOUT);

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [PtrW-1:0]        gnt_idx_q;
  logic [PtrW-1:0]        ptr_q;
  logic [CW-1:0]          cnt_q;
  logic                   timeout_q;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [PtrW-1:0]        pick_idx;
  logic [PtrW-1:0]        next_ptr;
  logic                   slv_resp;
  logic                   own_cyc;
  logic                   own_stb;

  logic [aw-1:0] adr_arr [NUM_MASTERS];
  logic [dw-1:0] dat_arr [NUM_MASTERS];
  logic [3:0]    sel_arr [NUM_MASTERS];
  logic [2:0]    cti_arr [NUM_MASTERS];
  logic [1:0]    bte_arr [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_slice
    assign adr_arr[k] = wbm_adr_i[k*aw +: aw];
    assign dat_arr[k] = wbm_dat_i[k*dw +: dw];
    assign sel_arr[k] = wbm_sel_i[k*4 +: 4];
    assign cti_arr[k] = wbm_cti_i[k*3 +: 3];
    assign bte_arr[k] = wbm_bte_i[k*2 +: 2];
  end

  wb_rr_pick #(
    .N    (NUM_MASTERS),
    .PtrW (PtrW)
  ) u_pick (
    .req_i (wbm_cyc_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_gnt[i]) pick_idx = PtrW'(i);
    end
  end

  assign next_ptr = (gnt_idx_q == PtrW'(NUM_MASTERS - 1)) ? '0 : gnt_idx_q + 1'b1;
  assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign own_cyc  = wbm_cyc_i[gnt_idx_q];
  assign own_stb  = wbm_stb_i[gnt_idx_q];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      unique case (state_q)
        StIdle: begin
          if (|wbm_cyc_i) begin
            grant_q   <= pick_gnt;
            gnt_idx_q <= pick_idx;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          if (!own_cyc) begin
            grant_q <= '0;
            ptr_q   <= next_ptr;
            state_q <= StIdle;
          end else if (WdEn && own_stb && !slv_resp) begin
            // A response in the limit cycle falls outside this branch and wins.
            if (cnt_q == TimeoutCw) begin
              state_q   <= StAbort;
              timeout_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StAbort: begin
          if (!own_cyc) begin
            grant_q <= '0;
            ptr_q   <= next_ptr;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    if (state_q == StBusy) begin
      wbs_adr_o = adr_arr[gnt_idx_q];
      wbs_dat_o = dat_arr[gnt_idx_q];
      wbs_sel_o = sel_arr[gnt_idx_q];
      wbs_we_o  = wbm_we_i[gnt_idx_q];
      wbs_cyc_o = own_cyc;
      wbs_stb_o = own_stb;
      wbs_cti_o = cti_arr[gnt_idx_q];
      wbs_bte_o = bte_arr[gnt_idx_q];
    end
  end

  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
  assign wbm_ack_o = (state_q == StBusy) ? (grant_q & {NUM_MASTERS{wbs_ack_i}}) : '0;
  assign wbm_rty_o = (state_q == StBusy) ? (grant_q & {NUM_MASTERS{wbs_rty_i}}) : '0;
  // timeout_q is only ever set on entry to StAbort, giving the one-cycle err.
  assign wbm_err_o = ((state_q == StBusy) ? (grant_q & {NUM_MASTERS{wbs_err_i}}) : '0)
                   | (grant_q & {NUM_MASTERS{timeout_q}});
  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with two masters and an 8-cycle watchdog.
module tb_wb_rr_arbiter;
  import wb_arb_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NM = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW*NM-1:0] wbm_adr_i = '0;
  logic [DW*NM-1:0] wbm_dat_i = '0;
  logic [4*NM-1:0]  wbm_sel_i = '0;
  logic [NM-1:0]    wbm_we_i  = '0;
  logic [NM-1:0]    wbm_cyc_i = '0;
  logic [NM-1:0]    wbm_stb_i = '0;
  logic [3*NM-1:0]  wbm_cti_i = '0;
  logic [2*NM-1:0]  wbm_bte_i = '0;
  logic [DW*NM-1:0] wbm_dat_o;
  logic [NM-1:0]    wbm_ack_o;
  logic [NM-1:0]    wbm_err_o;
  logic [NM-1:0]    wbm_rty_o;
  logic [AW-1:0]    wbs_adr_o;
  logic [DW-1:0]    wbs_dat_o;
  logic [3:0]       wbs_sel_o;
  logic             wbs_we_o;
  logic             wbs_cyc_o;
  logic             wbs_stb_o;
  logic [2:0]       wbs_cti_o;
  logic [1:0]       wbs_bte_o;
  logic [DW-1:0]    wbs_dat_i = '0;
  logic             wbs_ack_i = 1'b0;
  logic             wbs_err_i = 1'b0;
  logic             wbs_rty_i = 1'b0;
  logic [NM-1:0]    grant_o;
  logic             timeout_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .dw          (DW),
    .aw          (AW),
    .NUM_MASTERS (NM),
    .TIMEOUT     (8),
    .CW          (11)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbm_adr_i (wbm_adr_i),
    .wbm_dat_i (wbm_dat_i),
    .wbm_sel_i (wbm_sel_i),
    .wbm_we_i  (wbm_we_i),
    .wbm_cyc_i (wbm_cyc_i),
    .wbm_stb_i (wbm_stb_i),
    .wbm_cti_i (wbm_cti_i),
    .wbm_bte_i (wbm_bte_i),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_o (wbm_ack_o),
    .wbm_err_o (wbm_err_o),
    .wbm_rty_o (wbm_rty_o),
    .wbs_adr_o (wbs_adr_o),
    .wbs_dat_o (wbs_dat_o),
    .wbs_sel_o (wbs_sel_o),
    .wbs_we_o  (wbs_we_o),
    .wbs_cyc_o (wbs_cyc_o),
    .wbs_stb_o (wbs_stb_o),
    .wbs_cti_o (wbs_cti_o),
    .wbs_bte_o (wbs_bte_o),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_i (wbs_ack_i),
    .wbs_err_i (wbs_err_i),
    .wbs_rty_i (wbs_rty_i),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- Reset, including async reset in the middle of a transfer
    repeat (2) tick();
    chk("rst_grant", 64'(grant_o), 64'h0);
    chk("rst_cyc", 64'(wbs_cyc_o), 64'h0);
    chk("rst_adr", 64'(wbs_adr_o), 64'h0);
    chk("rst_timeout", 64'(timeout_o), 64'h0);
    rst = 1'b0;
    wbm_adr_i[31:0] = 32'h40;
    wbm_cyc_i = 2'b01;
    wbm_stb_i = 2'b01;
    #1;
    chk("arb_latency_cyc", 64'(wbs_cyc_o), 64'h0);
    tick();
    chk("m0_granted_cyc", 64'(wbs_cyc_o), 64'h1);
    chk("m0_grant", 64'(grant_o), 64'h1);
    chk("m0_adr", 64'(wbs_adr_o), 64'h40);
    rst = 1'b1;
    #1;
    chk("async_rst_cyc", 64'(wbs_cyc_o), 64'h0);
    chk("async_rst_stb", 64'(wbs_stb_o), 64'h0);
    chk("async_rst_grant", 64'(grant_o), 64'h0);
    wbm_cyc_i = 2'b00;
    wbm_stb_i = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_cyc", 64'(wbs_cyc_o), 64'h0);
    chk("post_rst_ack", 64'(wbm_ack_o), 64'h0);
    chk("post_rst_grant", 64'(grant_o), 64'h0);

    // ---- Single master 1 read of 0x100
    wbm_adr_i[63:32] = 32'h100;
    wbm_cyc_i = 2'b10;
    wbm_stb_i = 2'b10;
    #1;
    chk("m1_cyc_not_yet", 64'(wbs_cyc_o), 64'h0);
    tick();
    chk("m1_cyc", 64'(wbs_cyc_o), 64'h1);
    chk("m1_adr", 64'(wbs_adr_o), 64'h100);
    chk("m1_grant", 64'(grant_o), 64'h2);
    chk("m1_no_ack_yet", 64'(wbm_ack_o), 64'h0);
    wbs_ack_i = 1'b1;
    wbs_dat_i = 32'hDEADBEEF;
    #1;
    chk("m1_ack", 64'(wbm_ack_o), 64'h2);
    chk("m1_rdata", 64'(wbm_dat_o[63:32]), 64'hDEADBEEF);
    tick();
    wbs_ack_i = 1'b0;
    wbs_dat_i = '0;
    wbm_cyc_i = 2'b00;
    wbm_stb_i = 2'b00;
    #1;
    chk("m1_drop_cyc", 64'(wbs_cyc_o), 64'h0);
    tick();
    chk("m1_release", 64'(grant_o), 64'h0);

    // ---- Contention: both request, ptr=0 -> master 0 first
    wbm_adr_i[31:0]  = 32'hA0;
    wbm_adr_i[63:32] = 32'hB0;
    wbm_dat_i[31:0]  = 32'h1234_5678;
    wbm_sel_i[3:0]   = 4'hF;
    wbm_we_i  = 2'b01;
    wbm_cyc_i = 2'b11;
    wbm_stb_i = 2'b11;
    tick();
    chk("cont_first_m0", 64'(grant_o), 64'h1);
    chk("cont_adr_m0", 64'(wbs_adr_o), 64'hA0);
    chk("cont_wdat_m0", 64'(wbs_dat_o), 64'h1234_5678);
    chk("cont_sel_m0", 64'(wbs_sel_o), 64'hF);
    chk("cont_we_m0", 64'(wbs_we_o), 64'h1);
    wbs_ack_i = 1'b1;
    #1;
    chk("cont_ack_m0_only", 64'(wbm_ack_o), 64'h1);
    tick();
    wbs_ack_i = 1'b0;
    wbm_cyc_i = 2'b10;
    wbm_stb_i = 2'b10;
    tick();
    chk("cont_dead_grant", 64'(grant_o), 64'h0);
    chk("cont_dead_cyc", 64'(wbs_cyc_o), 64'h0);
    wbm_cyc_i = 2'b11;
    wbm_stb_i = 2'b11;
    tick();
    chk("cont_second_m1", 64'(grant_o), 64'h2);
    chk("cont_adr_m1", 64'(wbs_adr_o), 64'hB0);
    tick();
    chk("cont_m1_held", 64'(grant_o), 64'h2);
    wbm_cyc_i = 2'b01;
    wbm_stb_i = 2'b01;
    tick();
    chk("cont_m1_release", 64'(grant_o), 64'h0);
    tick();
    chk("cont_m0_again", 64'(grant_o), 64'h1);
    wbm_cyc_i = 2'b00;
    wbm_stb_i = 2'b00;
    wbm_we_i  = 2'b00;
    tick();
    tick();

    // ---- Burst atomicity: ptr=1, master 0 requests alone first
    wbm_cti_i[2:0] = CtiIncr;
    wbm_cyc_i = 2'b01;
    wbm_stb_i = 2'b01;
    tick();
    chk("burst_grant_m0", 64'(grant_o), 64'h1);
    wbm_cyc_i = 2'b11;
    wbm_stb_i = 2'b11;
    for (int b = 0; b < 4; b++) begin
      wbm_cti_i[2:0]  = (b == 3) ? CtiEob : CtiIncr;
      wbm_adr_i[31:0] = 32'h200 + 32'(4 * b);
      wbs_ack_i = 1'b1;
      #1;
      chk($sformatf("burst_grant_b%0d", b), 64'(grant_o), 64'h1);
      chk($sformatf("burst_ack_b%0d", b), 64'(wbm_ack_o), 64'h1);
      chk($sformatf("burst_cti_b%0d", b), 64'(wbs_cti_o), (b == 3) ? 64'h7 : 64'h2);
      tick();
    end
    wbs_ack_i = 1'b0;
    chk("burst_still_m0", 64'(grant_o), 64'h1);
    wbm_cyc_i = 2'b10;
    wbm_stb_i = 2'b10;
    wbm_cti_i = '0;
    tick();
    chk("burst_dead", 64'(grant_o), 64'h0);
    tick();
    chk("burst_then_m1", 64'(grant_o), 64'h2);
    wbm_cyc_i = 2'b00;
    wbm_stb_i = 2'b00;
    tick();
    tick();

    // ---- Watchdog: no response, err 9 cycles after stb becomes visible
    wbm_cyc_i = 2'b01;
    wbm_stb_i = 2'b01;
    tick();
    chk("wd_stb_up", 64'(wbs_stb_o), 64'h1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("wd_noerr_%0d", i), 64'(wbm_err_o), 64'h0);
      chk($sformatf("wd_note_%0d", i), 64'(timeout_o), 64'h0);
    end
    tick();
    chk("wd_err", 64'(wbm_err_o), 64'h1);
    chk("wd_timeout", 64'(timeout_o), 64'h1);
    chk("wd_abort_cyc", 64'(wbs_cyc_o), 64'h0);
    chk("wd_abort_grant", 64'(grant_o), 64'h1);
    tick();
    chk("wd_err_once", 64'(wbm_err_o), 64'h0);
    chk("wd_timeout_once", 64'(timeout_o), 64'h0);
    tick();
    chk("wd_abort_hold_cyc", 64'(wbs_cyc_o), 64'h0);
    wbm_cyc_i = 2'b00;
    wbm_stb_i = 2'b00;
    tick();
    chk("wd_release", 64'(grant_o), 64'h0);

    // ---- Watchdog boundary: ack in the limit cycle wins
    wbm_cyc_i = 2'b01;
    wbm_stb_i = 2'b01;
    tick();
    for (int i = 1; i <= 7; i++) tick();
    tick();
    wbs_ack_i = 1'b1;
    #1;
    chk("wdb_ack", 64'(wbm_ack_o), 64'h1);
    chk("wdb_no_err", 64'(wbm_err_o), 64'h0);
    tick();
    wbs_ack_i = 1'b0;
    chk("wdb_no_timeout", 64'(timeout_o), 64'h0);
    chk("wdb_no_err_after", 64'(wbm_err_o), 64'h0);
    chk("wdb_still_busy", 64'(wbs_cyc_o), 64'h1);
    wbm_cyc_i = 2'b00;
    wbm_stb_i = 2'b00;
    tick();
    chk("wdb_release", 64'(grant_o), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
